// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register file debug dump reader: FSM encoding
// and the word/byte geometry helpers.
package regfile_dump_reader_pkg;

    localparam int NB_STATE = 3;

    localparam logic [NB_STATE-1:0] ST_IDLE    = 3'd0;
    localparam logic [NB_STATE-1:0] ST_CAPTURE = 3'd1;
    localparam logic [NB_STATE-1:0] ST_SEND    = 3'd2;
    localparam logic [NB_STATE-1:0] ST_NEXT    = 3'd3;
    localparam logic [NB_STATE-1:0] ST_DONE    = 3'd4;

    localparam int NB_REG_DEF  = 32;
    localparam int NB_ADDR_DEF = 5;
    localparam int NB_BYTE_DEF = 8;

    localparam int BYTES_PER_REG = NB_REG_DEF / NB_BYTE_DEF;
    localparam int NUM_REGS      = 2 ** NB_ADDR_DEF;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one captured register word and hands it out MSB byte first over a
// valid/ready stream; valid stays up until the final byte is accepted.
module word_serializer
    import regfile_dump_reader_pkg::*;
#(
    parameter int NB_REG  = NB_REG_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [NB_REG-1:0]  word,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               last_accepted
);

    localparam int BPR    = NB_REG / NB_BYTE;
    localparam int NB_CNT = cnt_width(BPR);
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BPR - 1);

    logic [NB_REG-1:0] shift;
    logic [NB_CNT-1:0] byte_cnt;
    logic              handshake;

    assign handshake     = tx_valid & tx_ready;
    assign last_accepted = handshake && (byte_cnt == LAST_BYTE);
    assign tx_data       = shift[NB_REG-1 -: NB_BYTE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            byte_cnt <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shift    <= word;
            byte_cnt <= '0;
            tx_valid <= 1'b1;
        end else if (last_accepted) begin
            tx_valid <= 1'b0;
        end else if (handshake) begin
            shift    <= shift << NB_BYTE;
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register through the debug port and streams each word out as
// bytes; o_busy lets the top level freeze the pipeline for a clean snapshot.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int NB_REG  = NB_REG_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_ADDR-1:0] o_dunit_addr,
    input  logic [NB_REG-1:0]  i_dunit_reg,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready
);

    localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;

    logic [NB_STATE-1:0] state;
    logic [NB_STATE-1:0] next_state;
    logic                load;
    logic                last_accepted;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (i_start) next_state = ST_CAPTURE;
            ST_CAPTURE: next_state = ST_SEND;
            ST_SEND:    if (last_accepted) next_state = ST_NEXT;
            ST_NEXT:    next_state = (o_dunit_addr == ADDR_LAST) ? ST_DONE : ST_CAPTURE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != ST_IDLE);
        o_done = (state == ST_DONE);
        load   = (state == ST_CAPTURE);
    end

    // Address is registered a cycle ahead of CAPTURE so the combinational read settles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            o_dunit_addr <= '0;
        else if (state == ST_IDLE && i_start)
            o_dunit_addr <= '0;
        else if (state == ST_NEXT && o_dunit_addr != ADDR_LAST)
            o_dunit_addr <= o_dunit_addr + 1'b1;
    end

    word_serializer #(
        .NB_REG  (NB_REG),
        .NB_BYTE (NB_BYTE)
    ) u_ser (
        .clk           (i_clk),
        .rst_n         (i_reset),
        .load          (load),
        .word          (i_dunit_reg),
        .tx_data       (o_tx_data),
        .tx_valid      (o_tx_valid),
        .tx_ready      (i_tx_ready),
        .last_accepted (last_accepted)
    );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dumps with and without
// backpressure, start-while-busy, and abort/restart via reset.
module tb_regfile_dump_reader;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [4:0]  o_dunit_addr;
    logic [31:0] i_dunit_reg;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;

    logic [31:0] regs [32];
    logic [7:0]  got [$];
    int          total;
    int          bad;
    int          done_cnt;
    int          done_cyc;

    assign i_dunit_reg = regs[o_dunit_addr];

    regfile_dump_reader dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_dunit_addr (o_dunit_addr),
        .i_dunit_reg  (i_dunit_reg),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Starts a dump and records accepted bytes; samples on negedges.
    task automatic run_dump(input int ready_pct, input int busy_start_at,
                            input int budget, input bit check_lat);
        bit         pulsed;
        bit         prev_stall;
        logic [7:0] prev_data;
        got.delete();
        done_cnt   = 0;
        done_cyc   = 0;
        pulsed     = 0;
        prev_stall = 0;
        prev_data  = '0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            i_start    = 1'b0;
            i_tx_ready = ($urandom_range(99) < ready_pct);
            if (prev_stall) begin
                chk("hold_valid", {31'd0, o_tx_valid}, 32'd1);
                chk("hold_data", {24'd0, o_tx_data}, {24'd0, prev_data});
            end
            if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
            if (busy_start_at >= 0 && !pulsed && got.size() == busy_start_at) begin
                i_start = 1'b1;
                pulsed  = 1;
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_data  = o_tx_data;
            if (o_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = c;
                    chk("addr_at_done", {27'd0, o_dunit_addr}, 32'd31);
                end
            end
            if (done_cnt > 0 && c >= done_cyc + 4) break;
            @(negedge clk);
        end
        i_start    = 1'b0;
        i_tx_ready = 1'b1;
        if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
        chk("done_pulses", done_cnt, 32'd1);
        chk("byte_count", got.size(), 32'd128);
        chk("busy_after", {31'd0, o_busy}, 32'd0);
        if (check_lat) chk("done_latency", done_cyc, 32'd193);
    endtask

    task automatic check_stream(input string tag);
        int n;
        n = (got.size() < 128) ? got.size() : 128;
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]},
                {24'd0, regs[i/4][(3 - i%4)*8 +: 8]});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_tx_ready = 1'b1;
        for (int k = 0; k < 32; k++) regs[k] = k * 32'h01010101;
        regs[31] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        chk("rst_busy",  {31'd0, o_busy},     32'd0);
        chk("rst_done",  {31'd0, o_done},     32'd0);
        chk("rst_valid", {31'd0, o_tx_valid}, 32'd0);
        chk("rst_addr",  {27'd0, o_dunit_addr}, 32'd0);
        chk("rst_data",  {24'd0, o_tx_data},  32'd0);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);

        // Full dump, sink always ready
        run_dump(100, -1, 1000, 1);
        check_stream("full");
        chk("full_b0", {24'd0, got[0]}, 32'h00);
        chk("full_b3", {24'd0, got[3]}, 32'h00);
        chk("full_b4", {24'd0, got[4]}, 32'h01);
        chk("full_b120", {24'd0, got[120]}, 32'h1E);
        chk("last_b0", {24'd0, got[124]}, 32'hDE);
        chk("last_b1", {24'd0, got[125]}, 32'hAD);
        chk("last_b2", {24'd0, got[126]}, 32'hBE);
        chk("last_b3", {24'd0, got[127]}, 32'hEF);

        // Backpressure at 30% ready
        run_dump(30, -1, 4000, 0);
        check_stream("bp");

        // Start pulse while busy must be ignored
        run_dump(100, 50, 1000, 1);
        check_stream("busy_start");

        // Abort at register 12 byte 2 via reset, then restart
        regs[0] = 32'hA1B2C3D4;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (75) @(negedge clk);
        chk("abort_pre_valid", {31'd0, o_tx_valid}, 32'd1);
        chk("abort_pre_data",  {24'd0, o_tx_data},  32'h0C);
        chk("abort_pre_addr",  {27'd0, o_dunit_addr}, 32'd12);
        #2 i_reset = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, o_busy},     32'd0);
        chk("abort_valid", {31'd0, o_tx_valid}, 32'd0);
        chk("abort_data",  {24'd0, o_tx_data},  32'd0);
        chk("abort_addr",  {27'd0, o_dunit_addr}, 32'd0);
        chk("abort_done",  {31'd0, o_done},     32'd0);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        chk("abort_idle", {31'd0, o_busy}, 32'd0);
        run_dump(100, -1, 1000, 1);
        chk("restart_b0", {24'd0, got[0]}, 32'hA1);
        chk("restart_b1", {24'd0, got[1]}, 32'hB2);
        chk("restart_b2", {24'd0, got[2]}, 32'hC3);
        chk("restart_b3", {24'd0, got[3]}, 32'hD4);
        check_stream("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
